// File: rtl/scl_pkg.sv
// Shared definitions for the L=2 SCL path-metric update stage.
// Contains the FSM encoding and the saturating PM arithmetic helpers.
package scl_pkg;

   localparam int unsigned L           = 2;
   localparam int unsigned INDEX_WIDTH = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      OUT  = 2'd2
   } pm_state_e;

   function automatic logic [31:0] pm_max(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   // A dead path (PM_MAX) stays dead whatever is added to it.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if ((a >= pm_max(w)) || (s > {1'b0, pm_max(w)}))
         return pm_max(w);
      return s[31:0];
   endfunction

   function automatic logic [31:0] abs_llr(input logic signed [31:0] v);
      return (v < 0) ? unsigned'(-v) : unsigned'(v);
   endfunction

endpackage

// File: rtl/pm_cand_gen.sv
// Combinational candidate builder: per path, the unpenalised PM and the PM plus |llr|.
// Packed outputs put cand0 at the MSBs; hard[l] is the hard decision of path l.
module pm_cand_gen
   import scl_pkg::*;
#(
   parameter int unsigned PM_WIDTH  = 8,
   parameter int unsigned LLR_WIDTH = 6
) (
   input  logic [LLR_WIDTH*L-1:0]  llr_in,
   input  logic [PM_WIDTH*L-1:0]   pm_in,
   output logic [PM_WIDTH*2*L-1:0] cand,
   output logic [L-1:0]            hard
);

   always_comb begin
      logic signed [LLR_WIDTH-1:0] llr_l;
      logic [PM_WIDTH-1:0]         pm_l;
      cand  = '0;
      hard  = '0;
      llr_l = '0;
      pm_l  = '0;
      for (int unsigned l = 0; l < L; l++) begin
         llr_l   = llr_in[(L-1-l)*LLR_WIDTH +: LLR_WIDTH];
         pm_l    = pm_in[(L-1-l)*PM_WIDTH +: PM_WIDTH];
         hard[l] = llr_l[LLR_WIDTH-1];
         cand[(2*L-1-2*l)*PM_WIDTH +: PM_WIDTH] = pm_l;
         cand[(2*L-2-2*l)*PM_WIDTH +: PM_WIDTH] =
            PM_WIDTH'(sat_add(32'(pm_l), abs_llr(32'(llr_l)), PM_WIDTH));
      end
   end

endmodule

// File: rtl/scl_pm_update.sv
// Path-metric update stage of the L=2 SCL decoder (IDLE -> SORT -> OUT).
// Optional PM_NORM_EN: subtract survivor0's PM from both survivors after every update.
module scl_pm_update
   import scl_pkg::*;
#(
   parameter int unsigned PM_WIDTH  = 8,
   parameter int unsigned LLR_WIDTH = 6
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                cw_start,
   input  logic                                frozen,
   input  logic [LLR_WIDTH*L-1:0]              llr_in,
   output logic [PM_WIDTH*2*L-1:0]             sort_pm,
   input  logic [(PM_WIDTH+INDEX_WIDTH)*L-1:0] sort_res,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [L-1:0]                        out_parent,
   output logic [L-1:0]                        out_bit,
   output logic [PM_WIDTH*L-1:0]               out_pm
);

   localparam logic [PM_WIDTH-1:0] PM_MAX = PM_WIDTH'(pm_max(PM_WIDTH));
   localparam int unsigned SW = PM_WIDTH + INDEX_WIDTH;

   pm_state_e              state, state_nxt;
   logic [PM_WIDTH*L-1:0]  pm_reg, pm_base;
   logic [PM_WIDTH*2*L-1:0] cand;
   logic [L-1:0]           hard, hard_q;
   logic                   frozen_q;
   logic                   accept;

   logic [SW-1:0]          surv0, surv1;
   logic [PM_WIDTH-1:0]    new_hi, new_lo, fz0, fz1;
   logic [L-1:0]           upd_parent, upd_bit;
   logic [PM_WIDTH*L-1:0]  upd_pm;

   assign pm_base = cw_start ? {{PM_WIDTH{1'b0}}, PM_MAX} : pm_reg;
   assign out_pm  = pm_reg;

   pm_cand_gen #(
      .PM_WIDTH  (PM_WIDTH),
      .LLR_WIDTH (LLR_WIDTH)
   ) u_cand_gen (
      .llr_in (llr_in),
      .pm_in  (pm_base),
      .cand   (cand),
      .hard   (hard)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            accept   = in_valid;
            if (in_valid) state_nxt = SORT;
         end
         SORT: state_nxt = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Survivor packing: survivor0 at MSBs of out_parent/out_bit/out_pm.
   always_comb begin
      surv0      = sort_res[2*SW-1 -: SW];
      surv1      = sort_res[SW-1:0];
      fz0        = hard_q[0] ? sort_pm[3*PM_WIDTH-1 -: PM_WIDTH] : sort_pm[4*PM_WIDTH-1 -: PM_WIDTH];
      fz1        = hard_q[1] ? sort_pm[PM_WIDTH-1:0]            : sort_pm[2*PM_WIDTH-1 -: PM_WIDTH];
      new_hi     = surv0[PM_WIDTH-1:0];
      new_lo     = surv1[PM_WIDTH-1:0];
      upd_parent = {surv0[SW-1], surv1[SW-1]};
      upd_bit    = {hard_q[surv0[SW-1]] ^ surv0[SW-2], hard_q[surv1[SW-1]] ^ surv1[SW-2]};
      if (frozen_q) begin
         upd_bit = '0;
         if (fz1 < fz0) begin
            new_hi     = fz1;
            new_lo     = fz0;
            upd_parent = 2'b10;
         end else begin
            new_hi     = fz0;
            new_lo     = fz1;
            upd_parent = 2'b01;
         end
      end
`ifdef PM_NORM_EN
      upd_pm = {(new_hi == PM_MAX) ? PM_MAX : {PM_WIDTH{1'b0}},
                (new_lo == PM_MAX) ? PM_MAX : new_lo - new_hi};
`else
      upd_pm = {new_hi, new_lo};
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sort_pm    <= '0;
         pm_reg     <= {{PM_WIDTH{1'b0}}, PM_MAX};
         hard_q     <= '0;
         frozen_q   <= 1'b0;
         out_parent <= '0;
         out_bit    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            sort_pm  <= cand;
            hard_q   <= hard;
            frozen_q <= frozen;
         end
         if (state == SORT) begin
            pm_reg     <= upd_pm;
            out_parent <= upd_parent;
            out_bit    <= upd_bit;
         end
      end
   end

endmodule

// File: tb/tb_scl_pm_update.sv
// Directed bench for scl_pm_update with a behavioural L=2 sorter (stable, lowest index wins ties).
module tb_scl_pm_update;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cw_start, frozen;
   logic [11:0] llr_in;
   logic [31:0] sort_pm;
   logic [19:0] sort_res;
   logic        out_valid, out_ready;
   logic [1:0]  out_parent, out_bit;
   logic [15:0] out_pm;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   scl_pm_update #(
      .PM_WIDTH  (8),
      .LLR_WIDTH (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cw_start   (cw_start),
      .frozen     (frozen),
      .llr_in     (llr_in),
      .sort_pm    (sort_pm),
      .sort_res   (sort_res),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parent (out_parent),
      .out_bit    (out_bit),
      .out_pm     (out_pm)
   );

   // Behavioural sorter: two smallest of four candidates, cand0 at MSBs.
   always_comb begin
      logic [7:0] c [4];
      int b0, b1;
      for (int i = 0; i < 4; i++) c[i] = sort_pm[31-8*i -: 8];
      b0 = 0;
      for (int i = 1; i < 4; i++) if (c[i] < c[b0]) b0 = i;
      b1 = (b0 == 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) if (i != b0 && c[i] < c[b1]) b1 = i;
      sort_res = {2'(b0), c[b0], 2'(b1), c[b1]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bit: accept in IDLE, check candidates in SORT, survivors in OUT, optional stall.
   task automatic beat(input bit cw, input bit frz,
                       input logic signed [5:0] l0, input logic signed [5:0] l1,
                       input bit csort, input logic [31:0] esort,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [1:0] epar, input logic [1:0] ebit,
                       input int stall);
      @(negedge clk);
      check("in_ready_idle", in_ready, 1);
      in_valid  = 1'b1;
      cw_start  = cw;
      frozen    = frz;
      llr_in    = {l0, l1};
      out_ready = (stall == 0);
      @(negedge clk);
      if (stall > 0) begin
         cw_start = 1'b1;
         frozen   = ~frz;
         llr_in   = 12'hA5C;
      end else begin
         in_valid = 1'b0;
      end
      check("in_ready_sort", in_ready, 0);
      if (csort) check("sort_pm", sort_pm, esort);
      @(negedge clk);
      check("out_valid", out_valid, 1);
      check("out_pm", out_pm, {e0, e1});
      check("out_parent", out_parent, epar);
      check("out_bit", out_bit, ebit);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_ready", in_ready, 0);
         check("stall_pm", out_pm, {e0, e1});
         check("stall_parent", out_parent, epar);
      end
      if (stall > 0) begin
         out_ready = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         check("resume_ready", in_ready, 1);
         check("resume_valid", out_valid, 0);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; cw_start = 1'b0; frozen = 1'b0;
      llr_in = '0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_parent", out_parent, 0);
      check("rst_bit", out_bit, 0);
      check("rst_sort_pm", sort_pm, 0);
      check("rst_pm", out_pm, 16'h00FF);
      rst = 1'b0;

      beat(1, 0,  6'sd5,   6'sd0, 1, 32'h0005FFFF,   0,   5, 2'b00, 2'b01, 0);
      beat(0, 0, -6'sd3,   6'sd2, 1, 32'h00030507,   0,   3, 2'b00, 2'b10, 0);
      beat(0, 1, -6'sd4,   6'sd1, 1, 32'h00040304,   3,   4, 2'b10, 2'b00, 0);
      for (int k = 1; k <= 7; k++)
         beat(0, 1, -6'sd32, -6'sd32, 0, 0, 8'(3 + 32*k), 8'(4 + 32*k), 2'b01, 2'b00, 0);
      beat(0, 1, -6'sd23, -6'sd24, 0, 0,                250, 252, 2'b01, 2'b00, 0);
      beat(0, 1,  6'sd31, -6'sd32, 1, 32'hFAFFFCFF,    250, 255, 2'b01, 2'b00, 0);
      beat(0, 0,  6'sd31, -6'sd32, 1, 32'hFAFFFFFF,    250, 255, 2'b00, 2'b01, 5);

      // Reset while in SORT aborts the bit.
      @(negedge clk);
      in_valid = 1'b1; cw_start = 1'b0; frozen = 1'b0; llr_in = {6'sd7, 6'sd7};
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_sort_pm", sort_pm, 0);
      check("abort_pm", out_pm, 16'h00FF);

      beat(0, 1,  6'sd1,  6'sd1, 1, 32'h0001FFFF,   0, 255, 2'b01, 2'b00, 0);
      beat(1, 0,  6'sd2,  6'sd0, 1, 32'h0002FFFF,   0,   2, 2'b00, 2'b01, 0);
      beat(0, 1, -6'sd2,  6'sd0, 1, 32'h00020202,   2,   2, 2'b01, 2'b00, 0);

      @(negedge clk);
      check("final_idle", in_ready, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
